// File: rtl/prbs31_checker.sv
// -----------------------------------------------------------------------------
// prbs31_checker
//   Receive-side checker for a PRBS31 (x^31 + x^28 + 1) serial stream. A local
//   31-bit history is seeded from the incoming bits and then checked against the
//   recurrence. After enough consecutive matches the checker locks, free-runs its
//   own LFSR and reports every received bit that disagrees with it.
//
//   Ports
//     clk         in   clock
//     rst_n       in   asynchronous reset, active-high (asserted when 1)
//     data_in     in   received serial bit, sampled only when data_valid=1
//     data_valid  in   qualifies data_in; idle cycles change no state
//     clear_cnt   in   synchronous clear of err_count (wins over an error)
//     locked      out  1 while in LOCKED
//     err_pulse   out  one-cycle pulse per mismatching bit while LOCKED
//     err_count   out  saturating count of LOCKED-state bit errors
//
//   State   | meaning
//   --------+---------------------------------------------------------------
//   SEED    | shifting the first 31 received bits into the history register
//   VERIFY  | self-synchronised compare; LOCK_COUNT matches in a row -> LOCKED
//   LOCKED  | free-running LFSR; count errors, ERR_THRESH per window -> SEED
// -----------------------------------------------------------------------------
module prbs31_checker #(
    parameter int LOCK_COUNT = 64,
    parameter int ERR_WINDOW = 256,
    parameter int ERR_THRESH = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_in,
    input  logic             data_valid,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [1:0] ST_SEED   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W  = $clog2(ERR_WINDOW + 1);
    localparam int WERR_W = $clog2(ERR_THRESH + 1);

    logic [1:0]       state_q,     state_d;
    logic [30:0]      r_q,         r_d;
    logic [4:0]       seed_cnt_q,  seed_cnt_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    logic [WIN_W-1:0] win_bits_q,  win_bits_d;
    logic [WERR_W-1:0] win_err_q,  win_err_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic              pred;
    logic              err_hit;
    logic [30:0]       r_shift_in;
    logic [GOOD_W-1:0] good_inc;
    logic [WIN_W-1:0]  win_bits_inc;
    logic [WERR_W-1:0] win_err_inc;

    assign pred         = r_q[27] ^ r_q[30];
    assign r_shift_in   = {r_q[29:0], data_in};
    assign good_inc     = good_cnt_q + GOOD_W'(1);
    assign win_bits_inc = win_bits_q + WIN_W'(1);

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        seed_cnt_d  = seed_cnt_q;
        good_cnt_d  = good_cnt_q;
        win_bits_d  = win_bits_q;
        win_err_d   = win_err_q;
        err_hit     = 1'b0;
        win_err_inc = win_err_q;

        if (data_valid) begin
            case (state_q)
                ST_SEED: begin
                    r_d = r_shift_in;
                    if (seed_cnt_q == 5'd30) begin
                        state_d    = ST_VERIFY;
                        seed_cnt_d = '0;
                        good_cnt_d = '0;
                    end else begin
                        seed_cnt_d = seed_cnt_q + 5'd1;
                    end
                end

                ST_VERIFY: begin
                    // The received bit is shifted in regardless, so the history
                    // tracks the line and a mismatch simply restarts seeding.
                    r_d = r_shift_in;
                    if (data_in != pred) begin
                        state_d    = ST_SEED;
                        seed_cnt_d = '0;
                    end else if (good_inc == GOOD_W'(LOCK_COUNT)) begin
                        // An all-zero history satisfies the recurrence forever;
                        // refuse to lock onto a dead line.
                        if (r_shift_in == '0) begin
                            state_d    = ST_SEED;
                            seed_cnt_d = '0;
                        end else begin
                            state_d    = ST_LOCKED;
                            win_bits_d = '0;
                            win_err_d  = '0;
                        end
                    end else begin
                        good_cnt_d = good_inc;
                    end
                end

                ST_LOCKED: begin
                    // Free-run on the prediction so one corrupted line bit is
                    // reported once instead of three times.
                    r_d         = {r_q[29:0], pred};
                    err_hit     = (data_in != pred);
                    win_err_inc = win_err_q + WERR_W'(err_hit);
                    // Threshold check comes before the window rollover so an
                    // error on the last bit of a window still counts there.
                    if (err_hit && (win_err_inc == WERR_W'(ERR_THRESH))) begin
                        state_d    = ST_SEED;
                        seed_cnt_d = '0;
                    end else if (win_bits_inc == WIN_W'(ERR_WINDOW)) begin
                        win_bits_d = '0;
                        win_err_d  = '0;
                    end else begin
                        win_bits_d = win_bits_inc;
                        win_err_d  = win_err_inc;
                    end
                end

                default: begin
                    state_d    = ST_SEED;
                    seed_cnt_d = '0;
                end
            endcase
        end

        err_pulse_d = err_hit;

        if (clear_cnt) begin
            err_count_d = '0;
        end else if (err_hit && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + CNT_W'(1);
        end else begin
            err_count_d = err_count_q;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= ST_SEED;
            r_q         <= '0;
            seed_cnt_q  <= '0;
            good_cnt_q  <= '0;
            win_bits_q  <= '0;
            win_err_q   <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            seed_cnt_q  <= seed_cnt_d;
            good_cnt_q  <= good_cnt_d;
            win_bits_q  <= win_bits_d;
            win_err_q   <= win_err_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = (state_q == ST_LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs31_checker
//   Drives a PRBS31 generator stream (seed 1, output = lfsr[30]) into two
//   checker instances (CNT_W=16 and CNT_W=4) sharing all inputs. Injected bit
//   errors push the expected valid-bit index of their err_pulse into exp_q; the
//   driver records the index of every observed err_pulse into obs_q.
// -----------------------------------------------------------------------------
module tb_prbs31_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_in;
    logic        data_valid;
    logic        clear_cnt;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic        locked4;
    logic        err_pulse4;
    logic [3:0]  err_count4;

    int          checks   = 0;
    int          failures = 0;
    logic [30:0] gen_q;
    int          vbit;
    int          exp_q[$];
    int          obs_q[$];

    always #5 clk = ~clk;

    prbs31_checker #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .clear_cnt  (clear_cnt),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_count  (err_count)
    );

    prbs31_checker #(.CNT_W(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .clear_cnt  (clear_cnt),
        .locked     (locked4),
        .err_pulse  (err_pulse4),
        .err_count  (err_count4)
    );

    // One clock of stimulus; a valid bit takes the next generator bit, inverted
    // when inv=1. Called and returns at posedge+1.
    task automatic send(input logic v, input logic inv, input logic clr);
        logic g;
        data_valid = v;
        clear_cnt  = clr;
        if (v) begin
            g       = gen_q[30];
            gen_q   = {gen_q[29:0], gen_q[27] ^ gen_q[30]};
            data_in = g ^ inv;
            vbit++;
        end else begin
            data_in = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        if (err_pulse) obs_q.push_back(v ? vbit : -1);
        data_valid = 1'b0;
        clear_cnt  = 1'b0;
    endtask

    task automatic send_clean(input int n);
        for (int i = 0; i < n; i++) send(1'b1, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        rst_n      = 1'b1;
        data_valid = 1'b0;
        clear_cnt  = 1'b0;
        data_in    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        gen_q = 31'd1;
        vbit  = 0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        data_valid = 1'b0;
        clear_cnt = 1'b0;
        data_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked: got %0b expected 0", locked); end
        checks++; if (err_pulse !== 1'b0) begin failures++; $display("FAIL reset_pulse: got %0b expected 0", err_pulse); end
        checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", err_count); end
        checks++; if (err_count4 !== 4'd0) begin failures++; $display("FAIL reset_count4: got %0d expected 0", err_count4); end
        apply_reset();
        repeat (5) send(1'b0, 1'b0, 1'b0);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_idle_locked: got %0b expected 0", locked); end
    endtask

    task automatic test_clean_lock();
        apply_reset();
        for (int i = 1; i <= 10000; i++) begin
            send(1'b1, 1'b0, 1'b0);
            if (i == 94) begin
                checks++; if (locked !== 1'b0) begin failures++; $display("FAIL lock_early_94: got %0b expected 0", locked); end
            end
            if (i == 95) begin
                checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lock_at_95: got %0b expected 1", locked); end
            end
        end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL clean_locked_end: got %0b expected 1", locked); end
        checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL clean_count: got %0d expected 0", err_count); end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL clean_pulses: got %0d expected 0", obs_q.size()); end
    endtask

    task automatic test_single_error();
        int e, o;
        apply_reset();
        send_clean(95);
        send_clean(40);
        exp_q.push_back(vbit + 1);
        send(1'b1, 1'b1, 1'b0);
        send_clean(300);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL single_locked: got %0b expected 1", locked); end
        checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL single_count: got %0d expected 1", err_count); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL single_pulse_idx: got none expected %0d", e);
            end else begin
                o = obs_q.pop_front();
                if (o != e) begin failures++; $display("FAIL single_pulse_idx: got %0d expected %0d", o, e); end
            end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL single_extra_pulses: got %0d expected 0", obs_q.size()); end
    endtask

    task automatic test_loss_relock();
        int e, o, n;
        apply_reset();
        send_clean(95);
        send_clean(10);
        for (int k = 0; k < 8; k++) begin
            send_clean(11);
            exp_q.push_back(vbit + 1);
            send(1'b1, 1'b1, 1'b0);
            if (k == 6) begin
                checks++; if (locked !== 1'b1) begin failures++; $display("FAIL loss_locked_after7: got %0b expected 1", locked); end
            end
            if (k == 7) begin
                checks++; if (locked !== 1'b0) begin failures++; $display("FAIL loss_locked_after8: got %0b expected 0", locked); end
                checks++; if (err_count !== 16'd8) begin failures++; $display("FAIL loss_count: got %0d expected 8", err_count); end
            end
        end
        n = 0;
        while (locked !== 1'b1 && n < 200) begin
            send(1'b1, 1'b0, 1'b0);
            n++;
        end
        checks++; if (n != 95) begin failures++; $display("FAIL relock_bits: got %0d expected 95", n); end
        checks++; if (err_count !== 16'd8) begin failures++; $display("FAIL relock_count_held: got %0d expected 8", err_count); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL loss_pulse_idx: got none expected %0d", e);
            end else begin
                o = obs_q.pop_front();
                if (o != e) begin failures++; $display("FAIL loss_pulse_idx: got %0d expected %0d", o, e); end
            end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL loss_extra_pulses: got %0d expected 0", obs_q.size()); end
    endtask

    task automatic test_stuck_line();
        logic ever;
        for (int b = 0; b < 2; b++) begin
            apply_reset();
            ever = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                data_valid = 1'b1;
                data_in    = 1'(b);
                @(posedge clk);
                #1;
                if (locked === 1'b1) ever = 1'b1;
                if (err_pulse) obs_q.push_back(-1);
            end
            data_valid = 1'b0;
            checks++; if (ever !== 1'b0) begin failures++; $display("FAIL stuck_%0d_locked: got 1 expected 0", b); end
            checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL stuck_%0d_pulses: got %0d expected 0", b, obs_q.size()); end
        end
    endtask

    task automatic test_sparse_valid_reset();
        int first, e, o;
        apply_reset();
        first = -1;
        for (int c = 0; c < 600; c++) begin
            send((c % 3) == 0, 1'b0, 1'b0);
            if (locked === 1'b1 && first < 0) first = vbit;
        end
        checks++; if (first != 95) begin failures++; $display("FAIL sparse_lock_bit: got %0d expected 95", first); end
        checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL sparse_count: got %0d expected 0", err_count); end
        exp_q.push_back(vbit + 1);
        send(1'b1, 1'b1, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL sparse_err_count: got %0d expected 1", err_count); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL sparse_pulse_idx: got none expected %0d", e);
            end else begin
                o = obs_q.pop_front();
                if (o != e) begin failures++; $display("FAIL sparse_pulse_idx: got %0d expected %0d", o, e); end
            end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL sparse_extra_pulses: got %0d expected 0", obs_q.size()); end
        // Assert reset between clock edges and look before the next edge.
        #2;
        rst_n = 1'b1;
        #1;
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL async_rst_locked: got %0b expected 0", locked); end
        checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL async_rst_count: got %0d expected 0", err_count); end
        checks++; if (err_count4 !== 4'd0) begin failures++; $display("FAIL async_rst_count4: got %0d expected 0", err_count4); end
    endtask

    task automatic test_saturate_clear();
        int e, o;
        apply_reset();
        send_clean(95);
        for (int k = 0; k < 20; k++) begin
            send_clean(299);
            exp_q.push_back(vbit + 1);
            send(1'b1, 1'b1, 1'b0);
        end
        checks++; if (err_count4 !== 4'd15) begin failures++; $display("FAIL sat_count4: got %0d expected 15", err_count4); end
        checks++; if (err_count !== 16'd20) begin failures++; $display("FAIL sat_count16: got %0d expected 20", err_count); end
        checks++; if (locked !== 1'b1 || locked4 !== 1'b1) begin failures++; $display("FAIL sat_locked: got %0b/%0b expected 1/1", locked, locked4); end
        send_clean(299);
        exp_q.push_back(vbit + 1);
        send(1'b1, 1'b1, 1'b1);
        checks++; if (err_pulse4 !== 1'b1) begin failures++; $display("FAIL clr_err_pulse4: got %0b expected 1", err_pulse4); end
        checks++; if (err_count4 !== 4'd0) begin failures++; $display("FAIL clr_count4: got %0d expected 0", err_count4); end
        checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL clr_count16: got %0d expected 0", err_count); end
        send_clean(20);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL clr_locked: got %0b expected 1", locked); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL sat_pulse_idx: got none expected %0d", e);
            end else begin
                o = obs_q.pop_front();
                if (o != e) begin failures++; $display("FAIL sat_pulse_idx: got %0d expected %0d", o, e); end
            end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL sat_extra_pulses: got %0d expected 0", obs_q.size()); end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_single_error();
        test_loss_relock();
        test_stuck_line();
        test_sparse_valid_reset();
        test_saturate_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
